// File: rtl/pwm_multi.sv
// rtl/pwm_multi.sv - multi-channel PWM with shared counter, prescaler, double-buffered config and dead time
module pwm_multi #(
    parameter int CH_NUM     = 4,
    parameter int CNT_LENGTH = 16,
    parameter int DT_LENGTH  = 8,
    parameter int PSC_LENGTH = 8
) (
    input  logic                         pwm_clk,
    input  logic                         pwm_rst_n,
    input  logic                         pwm_en,
    input  logic                         cfg_load,
    input  logic                         mode,
    input  logic [PSC_LENGTH-1:0]        psc,
    input  logic [CNT_LENGTH-1:0]        max_val,
    input  logic [CH_NUM*CNT_LENGTH-1:0] duty_cycle,
    input  logic [DT_LENGTH-1:0]         dead_time,
    output logic [CH_NUM-1:0]            pwm_pos,
    output logic [CH_NUM-1:0]            pwm_neg,
    output logic                         period_end,
    output logic                         cfg_pending
);

    localparam logic [CNT_LENGTH-1:0] CNT_ONE = CNT_LENGTH'(1);
    localparam logic [DT_LENGTH-1:0]  DT_ONE  = DT_LENGTH'(1);

    // Shadow set (written by cfg_load) and active set (used by counter/compare)
    logic                         mode_s_q, mode_s_d;
    logic [PSC_LENGTH-1:0]        psc_s_q, psc_s_d;
    logic [CNT_LENGTH-1:0]        max_s_q, max_s_d;
    logic [CH_NUM*CNT_LENGTH-1:0] duty_s_q, duty_s_d;
    logic [DT_LENGTH-1:0]         dt_s_q, dt_s_d;

    logic                         mode_a_q, mode_a_d;
    logic [PSC_LENGTH-1:0]        psc_a_q, psc_a_d;
    logic [CNT_LENGTH-1:0]        max_a_q, max_a_d;
    logic [CH_NUM*CNT_LENGTH-1:0] duty_a_q, duty_a_d;
    logic [DT_LENGTH-1:0]         dt_a_q, dt_a_d;

    logic                         cfg_pending_q, cfg_pending_d;

    // Timebase
    logic [PSC_LENGTH-1:0]        psc_cnt_q, psc_cnt_d;
    logic [CNT_LENGTH-1:0]        cnt_q, cnt_d;
    logic                         dir_down_q, dir_down_d;
    logic                         boundary_q, boundary_d;
    logic                         period_end_q, period_end_d;

    // Per-channel state
    logic [CH_NUM-1:0]            raw;
    logic [CH_NUM-1:0]            raw_q, raw_d;
    logic [DT_LENGTH-1:0]         dt_cnt_q [CH_NUM];
    logic [DT_LENGTH-1:0]         dt_cnt_d [CH_NUM];
    logic [CH_NUM-1:0]            pos_q, pos_d;
    logic [CH_NUM-1:0]            neg_q, neg_d;

    logic                         tick;
    logic                         boundary;
    logic                         apply;
    logic [CNT_LENGTH-1:0]        cnt_next;
    logic                         dir_next;

    assign tick     = (psc_cnt_q == psc_a_q);
    assign boundary = pwm_en && tick && (cnt_next == '0);
    assign apply    = boundary && (cfg_load || cfg_pending_q);

    // Natural next counter value and direction for the active mode
    always_comb begin
        cnt_next = cnt_q;
        dir_next = dir_down_q;
        if (max_a_q == '0) begin
            cnt_next = '0;
            dir_next = 1'b0;
        end else if (!mode_a_q) begin
            cnt_next = (cnt_q >= max_a_q) ? '0 : cnt_q + 1'b1;
            dir_next = 1'b0;
        end else if (!dir_down_q) begin
            if (cnt_q >= max_a_q) begin
                cnt_next = max_a_q - 1'b1;
                // with max=1 the turn-around lands on 0, so stay counting up
                dir_next = (max_a_q > CNT_ONE);
            end else begin
                cnt_next = cnt_q + 1'b1;
            end
        end else begin
            if (cnt_q <= CNT_ONE) begin
                cnt_next = '0;
                dir_next = 1'b0;
            end else begin
                cnt_next = cnt_q - 1'b1;
            end
        end
    end

    // Prescaler, period counter and boundary/period_end pipeline
    always_comb begin
        psc_cnt_d    = psc_cnt_q;
        cnt_d        = cnt_q;
        dir_down_d   = dir_down_q;
        boundary_d   = boundary;
        period_end_d = boundary_q && pwm_en;
        if (!pwm_en) begin
            psc_cnt_d  = '0;
            cnt_d      = '0;
            dir_down_d = 1'b0;
        end else if (tick) begin
            psc_cnt_d  = '0;
            cnt_d      = cnt_next;
            dir_down_d = apply ? 1'b0 : dir_next;
        end else begin
            psc_cnt_d  = psc_cnt_q + 1'b1;
        end
    end

    // Config capture: ports -> shadow on cfg_load, shadow -> active at a boundary
    always_comb begin
        mode_s_d      = mode_s_q;
        psc_s_d       = psc_s_q;
        max_s_d       = max_s_q;
        duty_s_d      = duty_s_q;
        dt_s_d        = dt_s_q;
        mode_a_d      = mode_a_q;
        psc_a_d       = psc_a_q;
        max_a_d       = max_a_q;
        duty_a_d      = duty_a_q;
        dt_a_d        = dt_a_q;
        cfg_pending_d = cfg_pending_q;
        if (!pwm_en || (cfg_load && boundary)) begin
            mode_s_d      = mode;
            psc_s_d       = psc;
            max_s_d       = max_val;
            duty_s_d      = duty_cycle;
            dt_s_d        = dead_time;
            mode_a_d      = mode;
            psc_a_d       = psc;
            max_a_d       = max_val;
            duty_a_d      = duty_cycle;
            dt_a_d        = dead_time;
            cfg_pending_d = 1'b0;
        end else if (cfg_load) begin
            mode_s_d      = mode;
            psc_s_d       = psc;
            max_s_d       = max_val;
            duty_s_d      = duty_cycle;
            dt_s_d        = dead_time;
            cfg_pending_d = 1'b1;
        end else if (boundary && cfg_pending_q) begin
            mode_a_d      = mode_s_q;
            psc_a_d       = psc_s_q;
            max_a_d       = max_s_q;
            duty_a_d      = duty_s_q;
            dt_a_d        = dt_s_q;
            cfg_pending_d = 1'b0;
        end
    end

    // Raw compare per channel against the active duty
    always_comb begin
        for (int i = 0; i < CH_NUM; i++) begin
            raw[i] = (cnt_q >= duty_a_q[i*CNT_LENGTH +: CNT_LENGTH]);
        end
    end

    // Dead-time insertion: any raw edge blanks both sides for dt_a clocks
    always_comb begin
        raw_d = raw_q;
        pos_d = '0;
        neg_d = '0;
        for (int i = 0; i < CH_NUM; i++) begin
            dt_cnt_d[i] = dt_cnt_q[i];
            if (!pwm_en) begin
                raw_d[i]    = 1'b0;
                dt_cnt_d[i] = '0;
            end else if (raw[i] != raw_q[i]) begin
                raw_d[i] = raw[i];
                if (dt_a_q != '0) begin
                    dt_cnt_d[i] = dt_a_q;
                end else begin
                    dt_cnt_d[i] = '0;
                    pos_d[i]    = raw[i];
                    neg_d[i]    = ~raw[i];
                end
            end else if (dt_cnt_q[i] != '0) begin
                dt_cnt_d[i] = dt_cnt_q[i] - 1'b1;
                if (dt_cnt_q[i] == DT_ONE) begin
                    pos_d[i] = raw_q[i];
                    neg_d[i] = ~raw_q[i];
                end
            end else begin
                pos_d[i] = raw_q[i];
                neg_d[i] = ~raw_q[i];
            end
        end
    end

    // State registers; reset drops outputs asynchronously
    always_ff @(posedge pwm_clk or negedge pwm_rst_n) begin
        if (!pwm_rst_n) begin
            mode_s_q      <= 1'b0;
            psc_s_q       <= '0;
            max_s_q       <= '0;
            duty_s_q      <= '0;
            dt_s_q        <= '0;
            mode_a_q      <= 1'b0;
            psc_a_q       <= '0;
            max_a_q       <= '0;
            duty_a_q      <= '0;
            dt_a_q        <= '0;
            cfg_pending_q <= 1'b0;
            psc_cnt_q     <= '0;
            cnt_q         <= '0;
            dir_down_q    <= 1'b0;
            boundary_q    <= 1'b0;
            period_end_q  <= 1'b0;
            raw_q         <= '0;
            pos_q         <= '0;
            neg_q         <= '0;
            for (int i = 0; i < CH_NUM; i++) begin
                dt_cnt_q[i] <= '0;
            end
        end else begin
            mode_s_q      <= mode_s_d;
            psc_s_q       <= psc_s_d;
            max_s_q       <= max_s_d;
            duty_s_q      <= duty_s_d;
            dt_s_q        <= dt_s_d;
            mode_a_q      <= mode_a_d;
            psc_a_q       <= psc_a_d;
            max_a_q       <= max_a_d;
            duty_a_q      <= duty_a_d;
            dt_a_q        <= dt_a_d;
            cfg_pending_q <= cfg_pending_d;
            psc_cnt_q     <= psc_cnt_d;
            cnt_q         <= cnt_d;
            dir_down_q    <= dir_down_d;
            boundary_q    <= boundary_d;
            period_end_q  <= period_end_d;
            raw_q         <= raw_d;
            pos_q         <= pos_d;
            neg_q         <= neg_d;
            for (int i = 0; i < CH_NUM; i++) begin
                dt_cnt_q[i] <= dt_cnt_d[i];
            end
        end
    end

    assign pwm_pos     = pos_q;
    assign pwm_neg     = neg_q;
    assign period_end  = period_end_q;
    assign cfg_pending = cfg_pending_q;

endmodule

// File: doc/pwm_multi.md
# pwm_multi

Multi-channel PWM generator sharing one period counter across `CH_NUM` channels. It adds a clock prescaler, edge-aligned and center-aligned counting, and double-buffered configuration that is applied only at period boundaries (glitch-free). Each channel drives a complementary pair with programmable dead time. It sits behind the AXI-to-GPIO register bank and drives motor/LED pins directly.

## Interface
- `CH_NUM`, 4: number of channels.
- `CNT_LENGTH`, 16: period counter, `max_val` and duty width.
- `DT_LENGTH`, 8: dead-time counter width.
- `PSC_LENGTH`, 8: prescaler width.
- `pwm_clk` in 1: clock.
- `pwm_rst_n` in 1: reset, asynchronous, active-low.
- `pwm_en` in 1: run enable.
- `cfg_load` in 1: one-cycle pulse; captures all config ports below into shadow registers.
- `mode` in 1: 0 = edge-aligned, 1 = center-aligned.
- `psc` in `PSC_LENGTH`: prescale; counter ticks every `psc`+1 clocks.
- `max_val` in `CNT_LENGTH`: counter top.
- `duty_cycle` in `CH_NUM*CNT_LENGTH`: channel i at bits [i*CNT_LENGTH +: CNT_LENGTH].
- `dead_time` in `DT_LENGTH`: dead time in `pwm_clk` cycles, shared by all channels.
- `pwm_pos` out `CH_NUM`: high-side outputs.
- `pwm_neg` out `CH_NUM`: low-side outputs.
- `period_end` out 1: one-cycle pulse per period boundary.
- `cfg_pending` out 1: shadow holds config not yet applied.

## Operation
**Register sets**
- Three config sets exist: ports, shadow, and active. The counter and compare logic use the active set only.
- `cfg_load` copies the ports into shadow and sets `cfg_pending`. A second `cfg_load` before the boundary overwrites the shadow.
- At a boundary tick with `cfg_pending`=1, the shadow is copied into active and `cfg_pending` is cleared.
- If `cfg_load` and a boundary tick fall on the same edge, the port values go straight to active and `cfg_pending` stays 0.

**Disabled state (`pwm_en`=0)**
- `cnt`=0, direction=up, and the prescaler count is 0.
- Active set is copied from the ports every cycle; shadow is copied as well; `cfg_pending`=0.
- All outputs are held at 0, dead-time counters are cleared, and `period_end`=0.

**Prescaler**
- `psc_cnt` counts 0..`psc`_act, and `tick` is asserted when `psc_cnt`==`psc`_act.
- With `psc`=0, `tick` is asserted every cycle.

**Counter, updated on `tick` only**
- Edge mode: `cnt` counts 0,1..`max`, then returns to 0. Comparisons use `cnt`>=`max`, so a reduced `max` wraps immediately. Period is `max`+1 ticks.
- Center mode: counts up to `max`, then down to 0; direction flips at `max` and at 0. Sequence for `max`=3 is 0,1,2,3,2,1,0,1… Period is 2·`max` ticks.
- `max`=0: `cnt` stays 0 in both modes.
- Boundary: a `tick` whose next `cnt` is 0. With `max`=0, every tick is a boundary.
- Leaving the disabled state starts a period at `cnt`=0 without signalling a boundary.
- When config is applied at a boundary, the new period starts with `cnt`=0 and direction=up.

**Channel compare and dead time**
- Raw compare: `raw[i]` = (`cnt` >= `duty[i]`_act).
  - `duty`=0 gives `raw`=1 permanently.
  - `duty`>`max` gives `raw`=0 permanently.
- Each channel holds `raw_q[i]` and a dead-time counter `dt[i]`.
- On a `raw` change:
  - `raw_q` is updated.
  - If `dead_time`_act>0, both outputs go 0 for exactly `dead_time` clocks, then `pos`=`raw_q` and `neg`=~`raw_q`.
  - If `dead_time`_act=0, outputs switch directly with no overlap gap.
- A `raw` change during a dead-time window reloads the window; both outputs stay 0. Pulses shorter than the dead time are therefore swallowed.
- `pwm_pos[i]` and `pwm_neg[i]` are never both 1 in any cycle.

## Timing
- Reset values: `pwm_pos`=0, `pwm_neg`=0, `period_end`=0, `cfg_pending`=0. `cnt`, `psc_cnt`, `dt`, and the shadow and active sets are all 0; direction=up.
- Outputs are registered. A `cnt` update on edge N gives an output change on edge N+1 when `dead_time`=0, or on edge N+1+`dead_time` after N+1…N+`dead_time` spent low.
- `period_end` is registered and goes high one clock after the boundary edge, for one clock.
- Deasserting `pwm_en` forces all outputs to 0 on the next edge.
- Asserting reset mid-period takes effect immediately: outputs go to 0 asynchronously.

## Test plan
- Edge mode: `max`=4, `psc`=0, dt=0, `duty`={0,2,5,3} → ch0 `pos` always 1; ch1 `pos` high 3 of every 5 clocks; ch2 `pos` always 0; ch3 high 2 of 5. `period_end` every 5 clocks.
- Center mode: `max`=4, `duty`=2 → 8-tick period, `pos` high for 5 consecutive ticks centered on `cnt`=4. `psc`=1 doubles all durations.
- Dead time 3, edge `max`=9, `duty`=5 → each transition shows exactly 3 clocks with `pos`=`neg`=0. `pos`&`neg` is never 1.
- Double buffering: mid-period `cfg_load` with `duty` 2→7 → `cfg_pending`=1, output unchanged until boundary. New duty applies from `cnt`=0, `cfg_pending`=0. Also check `cfg_load` coinciding with a boundary.
- Dead time 6 with a 2-tick pulse (`max`=9, `duty`=8, `psc`=0) → pulse suppressed and outputs stay 0 through the window. `pwm_en` dropping mid-period → outputs 0 next edge; re-enable restarts at `cnt`=0.
- Reset asserted mid-dead-time → all outputs and `cfg_pending` go to 0 immediately and stay 0 until enabled.
